// File: rtl/jk_mod_counter.sv
// Modulo-N register with per-bit JK, up/down count and clamped load modes.
// Flags a sticky error whenever the state would leave the 0..MODULUS-1 range.
module jk_mod_counter #(
    parameter int              WIDTH   = 8,
    parameter longint unsigned MODULUS = 256,
    parameter int              RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] d,
    input  logic             clr_err,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             tc,
    output logic             wrap,
    output logic             err
);

    // MODULUS may equal 2^WIDTH, so range checks use one extra bit.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RST_VAL);
    localparam logic [WIDTH-1:0] ZERO_Q  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_Q   = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] jk_result;
    logic             wrap_next;
    logic             err_set;
    logic             q_oor;
    logic             jk_oor;
    logic             d_oor;

    assign jk_result = (j & ~q) | (~k & q);
    assign q_oor     = ({1'b0, q} >= MOD_EXT);
    assign jk_oor    = ({1'b0, jk_result} >= MOD_EXT);
    assign d_oor     = ({1'b0, d} >= MOD_EXT);

    assign tc = en && (((mode == 2'b01) && (q == MAX_Q)) ||
                       ((mode == 2'b10) && (q == ZERO_Q)));

    // Next-state selection for q plus the wrap and error events it produces.
    always_comb begin
        q_next    = q;
        wrap_next = 1'b0;
        err_set   = 1'b0;
        if (en) begin
            case (mode)
                2'b00: begin
                    q_next  = jk_result;
                    err_set = jk_oor;
                end
                2'b01: begin
                    if (q_oor) begin
                        q_next  = ZERO_Q;
                        err_set = 1'b1;
                    end else if (q == MAX_Q) begin
                        q_next    = ZERO_Q;
                        wrap_next = 1'b1;
                    end else begin
                        q_next = q + ONE_Q;
                    end
                end
                2'b10: begin
                    if (q_oor) begin
                        q_next  = ZERO_Q;
                        err_set = 1'b1;
                    end else if (q == ZERO_Q) begin
                        q_next    = MAX_Q;
                        wrap_next = 1'b1;
                    end else begin
                        q_next = q - ONE_Q;
                    end
                end
                2'b11: begin
                    if (d_oor) begin
                        q_next  = MAX_Q;
                        err_set = 1'b1;
                    end else begin
                        q_next = d;
                    end
                end
                default: begin
                    q_next = q;
                end
            endcase
        end else begin
            q_next = q;
        end
    end

    // State and flag registers; q_bar is loaded alongside q so it never skews.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q     <= RST_Q;
            q_bar <= ~RST_Q;
            wrap  <= 1'b0;
            err   <= 1'b0;
        end else begin
            q     <= q_next;
            q_bar <= ~q_next;
            wrap  <= wrap_next;
            if (err_set) begin
                err <= 1'b1;
            end else if (clr_err) begin
                err <= 1'b0;
            end else begin
                err <= err;
            end
        end
    end

endmodule

// File: tb/tb_jk_mod_counter.sv
// Directed bench: three counters (4-bit mod 10 reset 0 and 3, 8-bit mod 256)
// driven from a shared stimulus bus.
module tb_jk_mod_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [7:0] j;
    logic [7:0] k;
    logic [7:0] d;
    logic       clr_err;

    logic [3:0] q_a, q_bar_a, inv_a;
    logic       tc_a, wrap_a, err_a;
    logic [3:0] q_c, q_bar_c, inv_c;
    logic       tc_c, wrap_c, err_c;
    logic [7:0] q_b, q_bar_b, inv_b;
    logic       tc_b, wrap_b, err_b;

    int checks = 0;
    int errors = 0;
    bit run_inv = 1'b0;

    assign inv_a = ~q_a;
    assign inv_c = ~q_c;
    assign inv_b = ~q_b;

    always #5 clk = ~clk;

    jk_mod_counter #(.WIDTH(4), .MODULUS(10), .RST_VAL(0)) dut_a (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j[3:0]), .k(k[3:0]),
        .d(d[3:0]), .clr_err(clr_err), .q(q_a), .q_bar(q_bar_a), .tc(tc_a),
        .wrap(wrap_a), .err(err_a));

    jk_mod_counter #(.WIDTH(4), .MODULUS(10), .RST_VAL(3)) dut_c (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j[3:0]), .k(k[3:0]),
        .d(d[3:0]), .clr_err(clr_err), .q(q_c), .q_bar(q_bar_c), .tc(tc_c),
        .wrap(wrap_c), .err(err_c));

    jk_mod_counter #(.WIDTH(8), .MODULUS(256), .RST_VAL(0)) dut_b (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k),
        .d(d), .clr_err(clr_err), .q(q_b), .q_bar(q_bar_b), .tc(tc_b),
        .wrap(wrap_b), .err(err_b));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Complement invariant on every cycle, including while reset is held.
    always @(negedge clk) begin
        if (run_inv) begin
            check("qbar_inv_a", q_bar_a, inv_a);
            check("qbar_inv_c", q_bar_c, inv_c);
            check("qbar_inv_b", q_bar_b, inv_b);
        end
    end

    initial begin
        rst = 1'b1; en = 1'b0; mode = 2'b00; j = 8'h00; k = 8'h00; d = 8'h00; clr_err = 1'b0;
        #1;
        check("rst_q_a", q_a, 4'h0);
        check("rst_qbar_a", q_bar_a, 4'hF);
        check("rst_wrap_a", wrap_a, 1'b0);
        check("rst_err_a", err_a, 1'b0);
        check("rst_q_c", q_c, 4'h3);
        check("rst_qbar_c", q_bar_c, 4'hC);
        run_inv = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Count up through the modulus boundary.
        en = 1'b1; mode = 2'b01;
        for (int i = 1; i <= 12; i++) begin
            check("up_tc", tc_a, ((i - 1) % 10) == 9);
            tick();
            check("up_q", q_a, i % 10);
            check("up_wrap", wrap_a, i == 10);
            @(negedge clk);
        end

        // Load 0, then count down through zero.
        mode = 2'b11; d = 8'h00;
        tick();
        check("ld0_q", q_a, 4'h0);
        check("ld0_err", err_a, 1'b0);
        @(negedge clk);
        mode = 2'b10;
        #1 check("dn_tc0", tc_a, 1'b1);
        tick();
        check("dn_q9", q_a, 4'h9);
        check("dn_wrap1", wrap_a, 1'b1);
        check("dn_tc9", tc_a, 1'b0);
        @(negedge clk);
        tick();
        check("dn_q8", q_a, 4'h8);
        check("dn_wrap0", wrap_a, 1'b0);
        @(negedge clk);

        // JK mode producing an out-of-range value, then recovery by counting.
        mode = 2'b11; d = 8'h05;
        tick();
        check("ld5_q", q_a, 4'h5);
        @(negedge clk);
        mode = 2'b00; j = 8'h0A; k = 8'h03;
        #1 check("jk_tc", tc_a, 1'b0);
        tick();
        check("jk_q", q_a, 4'hE);
        check("jk_qbar", q_bar_a, 4'h1);
        check("jk_err", err_a, 1'b1);
        check("jk_wrap", wrap_a, 1'b0);
        @(negedge clk);
        mode = 2'b01;
        #1 check("oor_tc", tc_a, 1'b0);
        tick();
        check("oor_q", q_a, 4'h0);
        check("oor_err", err_a, 1'b1);
        check("oor_wrap", wrap_a, 1'b0);
        @(negedge clk);

        // Clear error while disabled, clamped load, clear-vs-set priority.
        en = 1'b0; clr_err = 1'b1;
        tick();
        check("clr1_err", err_a, 1'b0);
        check("clr1_q", q_a, 4'h0);
        @(negedge clk);
        en = 1'b1; clr_err = 1'b0; mode = 2'b11; d = 8'h0C;
        tick();
        check("clamp_q", q_a, 4'h9);
        check("clamp_err", err_a, 1'b1);
        @(negedge clk);
        en = 1'b0; clr_err = 1'b1;
        tick();
        check("clr2_err", err_a, 1'b0);
        check("clr2_q", q_a, 4'h9);
        @(negedge clk);
        en = 1'b1; clr_err = 1'b1; mode = 2'b11; d = 8'h0C;
        tick();
        check("prio_err", err_a, 1'b1);
        check("prio_q", q_a, 4'h9);
        @(negedge clk);
        en = 1'b0; clr_err = 1'b0; mode = 2'b01;
        #1 check("hold_tc", tc_a, 1'b0);
        tick();
        check("hold_q", q_a, 4'h9);
        check("hold_wrap", wrap_a, 1'b0);
        check("hold_err", err_a, 1'b1);
        @(negedge clk);

        // Asynchronous reset between edges mid-count.
        en = 1'b1; mode = 2'b01;
        tick();
        check("pre_rst_q", q_a, 4'h0);
        check("pre_rst_wrap", wrap_a, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("arst_q_c", q_c, 4'h3);
        check("arst_qbar_c", q_bar_c, 4'hC);
        check("arst_wrap_c", wrap_c, 1'b0);
        check("arst_err_c", err_c, 1'b0);
        check("arst_wrap_a", wrap_a, 1'b0);
        check("arst_err_a", err_a, 1'b0);
        tick();
        check("arst_hold_q_c", q_c, 4'h3);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("post_rst_q_c", q_c, 4'h4);
        check("post_rst_q_a", q_a, 4'h1);
        @(negedge clk);

        // Full-range 8-bit wrap in both directions.
        mode = 2'b11; d = 8'hFF;
        tick();
        check("b_ld_q", q_b, 8'hFF);
        check("b_ld_err", err_b, 1'b0);
        @(negedge clk);
        mode = 2'b01;
        #1 check("b_up_tc", tc_b, 1'b1);
        tick();
        check("b_up_q", q_b, 8'h00);
        check("b_up_qbar", q_bar_b, 8'hFF);
        check("b_up_wrap", wrap_b, 1'b1);
        check("b_up_err", err_b, 1'b0);
        @(negedge clk);
        mode = 2'b10;
        #1 check("b_dn_tc", tc_b, 1'b1);
        tick();
        check("b_dn_q", q_b, 8'hFF);
        check("b_dn_wrap", wrap_b, 1'b1);
        @(negedge clk);
        tick();
        check("b_dn2_q", q_b, 8'hFE);
        check("b_dn2_wrap", wrap_b, 1'b0);
        @(negedge clk);

        run_inv = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
